// File: rtl/serial_word_feeder_pkg.sv
// serial_word_feeder_pkg: shared state type and counter-width helper for the serial word feeder
package serial_word_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } feeder_state_t;

  // Counter width for a count of n positions, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: serialises handshaked parallel words into shift_en/dir/din for an N-bit shift register
// Optional build macro SERIAL_WORD_FEEDER_CHECK_EN adds q_in/check_err to verify the register contents at done.
module serial_word_feeder #(
  parameter int N   = 8,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  output logic         in_ready,
  output logic         shift_en,
  output logic         dir,
  output logic         din,
  output logic         busy,
  output logic         done
`ifdef SERIAL_WORD_FEEDER_CHECK_EN
  ,
  input  logic [N-1:0] q_in,
  output logic         check_err
`endif
);
  import serial_word_feeder_pkg::*;

  localparam int CW = cnt_w(N);
  localparam int GW = cnt_w(GAP);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  feeder_state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_idx;
  logic [GW-1:0] r_gcnt, w_gcnt_nx;
  logic [N-1:0]  r_word, w_word_nx;
  logic          r_dir, w_dir_nx;
  logic          r_shift_en, r_din, r_busy, r_done;
  logic          w_last, w_accept, w_bit;

  // Ready depends only on state and counters: idle, or the final cycle of the current word
  always_comb begin
    w_last   = (r_state == SHIFT) && (r_cnt == LAST);
    in_ready = (r_state == IDLE) ||
               ((GAP == 0) ? w_last
                           : ((r_state == serial_word_feeder_pkg::GAP) && (r_gcnt == GLAST)));
    w_accept = in_valid && in_ready;
  end

  // Next state, counters and latched word; the bit index walks MSB-first for left shifts
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_gcnt_nx  = r_gcnt;
    w_word_nx  = r_word;
    w_dir_nx   = r_dir;
    if (w_accept) begin
      w_state_nx = SHIFT;
      w_cnt_nx   = '0;
      w_word_nx  = in_data;
      w_dir_nx   = in_dir;
    end else if (r_state == SHIFT) begin
      w_cnt_nx = r_cnt + 1'b1;
      if (w_last) begin
        w_state_nx = (GAP > 0) ? serial_word_feeder_pkg::GAP : IDLE;
        w_gcnt_nx  = '0;
      end
    end else if (r_state == serial_word_feeder_pkg::GAP) begin
      w_gcnt_nx = r_gcnt + 1'b1;
      if (r_gcnt == GLAST) w_state_nx = IDLE;
    end
    w_idx = w_dir_nx ? (LAST - w_cnt_nx) : w_cnt_nx;
  end

  assign w_bit = w_word_nx[w_idx];

  // FSM state, counters and word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_word  <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_gcnt  <= w_gcnt_nx;
      r_word  <= w_word_nx;
      r_dir   <= w_dir_nx;
    end
  end

  // Registered register-side outputs, computed from next state so they line up with the shift cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_en <= 1'b0;
      r_din      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_shift_en <= (w_state_nx == SHIFT);
      r_din      <= (w_state_nx == SHIFT) && w_bit;
      r_busy     <= (w_state_nx != IDLE);
      r_done     <= w_last;
    end
  end

  assign shift_en = r_shift_en;
  assign dir      = r_dir;
  assign din      = r_din;
  assign busy     = r_busy;
  assign done     = r_done;

`ifdef SERIAL_WORD_FEEDER_CHECK_EN
  logic [N-1:0] r_done_word;
  logic         r_check_err;

  // Keep the completed word, since a streamed follow-on word may already own r_word during done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_word <= '0;
      r_check_err <= 1'b0;
    end else begin
      if (w_last) r_done_word <= r_word;
      r_check_err <= r_done && (q_in != r_done_word);
    end
  end

  assign check_err = r_check_err;

  a_q_match: assert property (@(posedge clk) disable iff (!rst_n) r_done |-> (q_in == r_done_word));
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: table vectors, hand-written corner sequences and randomized traffic against a cycle-level model
module tb_serial_word_feeder;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic         v[2];
  logic [N-1:0] d[2];
  logic         di[2];
  logic         rdy[2], se[2], dr[2], dn[2], bs[2], dne[2];
`ifdef SERIAL_WORD_FEEDER_CHECK_EN
  logic         ce[2];
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Cycle-level model: cycle index of the latest/previous accepted word and the downstream register
  int           cyc = 0;
  int           lk[2] = '{-1000, -1000};
  int           pk[2] = '{-1000, -1000};
  logic [N-1:0] ld[2] = '{'0, '0};
  logic [N-1:0] pd[2] = '{'0, '0};
  logic         ldir[2] = '{1'b0, 1'b0};
  logic [N-1:0] mq[2] = '{'0, '0};
  bit           mon_on = 1'b0;

  serial_word_feeder #(.N(N), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_data(d[0]), .in_dir(di[0]),
    .in_ready(rdy[0]), .shift_en(se[0]), .dir(dr[0]), .din(dn[0]), .busy(bs[0]), .done(dne[0])
`ifdef SERIAL_WORD_FEEDER_CHECK_EN
    , .q_in(mq[0]), .check_err(ce[0])
`endif
  );

  serial_word_feeder #(.N(N), .GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_data(d[1]), .in_dir(di[1]),
    .in_ready(rdy[1]), .shift_en(se[1]), .dir(dr[1]), .din(dn[1]), .busy(bs[1]), .done(dne[1])
`ifdef SERIAL_WORD_FEEDER_CHECK_EN
    , .q_in(mq[1]), .check_err(ce[1])
`endif
  );

  always #5 clk = ~clk;

  function automatic int gap_of(input int j);
    return (j == 0) ? 0 : 2;
  endfunction

  // A word accepted at edge k shifts in cycles k..k+N-1, so the next one may be taken from cycle k+N-1+GAP on
  function automatic bit m_ready(input int j, input int c);
    return c >= lk[j] + N - 1 + gap_of(j);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model update at each edge: downstream register shifts, handshake recorded from the model's own ready
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) begin
        lk[j]   <= -1000;
        pk[j]   <= -1000;
        ldir[j] <= 1'b0;
        mq[j]   <= '0;
      end else begin
        if (se[j]) mq[j] <= dr[j] ? {mq[j][N-2:0], dn[j]} : {dn[j], mq[j][N-1:1]};
        if (v[j] && m_ready(j, cyc)) begin
          pk[j]   <= lk[j];
          pd[j]   <= ld[j];
          lk[j]   <= cyc + 1;
          ld[j]   <= d[j];
          ldir[j] <= di[j];
        end
      end
    end
    cyc <= cyc + 1;
  end

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      for (int j = 0; j < 2; j++) begin
        int  c, i;
        bit  sh, dx;
        string p;
        c  = cyc;
        i  = c - lk[j];
        p  = (j == 0) ? "gap0" : "gap2";
        sh = (i >= 0) && (i <= N - 1);
        dx = (c == lk[j] + N) || (c == pk[j] + N);
        chk({p, ".in_ready"}, 32'(rdy[j]), 32'(m_ready(j, c)));
        chk({p, ".shift_en"}, 32'(se[j]), 32'(sh));
        chk({p, ".busy"}, 32'(bs[j]), 32'((i >= 0) && (i <= N - 1 + gap_of(j))));
        chk({p, ".dir"}, 32'(dr[j]), 32'(ldir[j]));
        chk({p, ".done"}, 32'(dne[j]), 32'(dx));
        if (sh) chk({p, ".din"}, 32'(dn[j]), 32'(ldir[j] ? ld[j][N-1-i] : ld[j][i]));
        if (dx) chk({p, ".q"}, 32'(mq[j]), 32'((c == lk[j] + N) ? ld[j] : pd[j]));
`ifdef SERIAL_WORD_FEEDER_CHECK_EN
        chk({p, ".check_err"}, 32'(ce[j]), 32'(0));
`endif
      end
    end
  end

  typedef struct {
    logic [N-1:0] data;
    logic         dir;
    logic [N-1:0] seq;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int se_cnt, zero_cnt, got;
    logic [31:0] pat;
    tbl[0] = '{8'hA5, 1'b1, 8'b10100101};
    tbl[1] = '{8'h01, 1'b0, 8'b10000000};
    tbl[2] = '{8'h3C, 1'b0, 8'b00111100};
    tbl[3] = '{8'h96, 1'b1, 8'b10010110};
    tbl[4] = '{8'hC8, 1'b0, 8'b00010011};
    for (int j = 0; j < 2; j++) begin
      v[j] = 1'b0; d[j] = '0; di[j] = 1'b0;
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("reset.shift_en", 32'(se[j]), 32'(0));
      chk("reset.dir", 32'(dr[j]), 32'(0));
      chk("reset.din", 32'(dn[j]), 32'(0));
      chk("reset.busy", 32'(bs[j]), 32'(0));
      chk("reset.done", 32'(dne[j]), 32'(0));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("release.in_ready0", 32'(rdy[0]), 32'(1));
    chk("release.in_ready2", 32'(rdy[1]), 32'(1));

    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      v[0] = 1'b1; d[0] = tbl[t].data; di[0] = tbl[t].dir;
      @(negedge clk);
      v[0] = 1'b0;
      for (int i = 0; i < N; i++) begin
        chk($sformatf("tbl%0d.shift_en[%0d]", t, i), 32'(se[0]), 32'(1));
        chk($sformatf("tbl%0d.din[%0d]", t, i), 32'(dn[0]), 32'(tbl[t].seq[N-1-i]));
        chk($sformatf("tbl%0d.dir[%0d]", t, i), 32'(dr[0]), 32'(tbl[t].dir));
        @(negedge clk);
      end
      chk($sformatf("tbl%0d.done", t), 32'(dne[0]), 32'(1));
      chk($sformatf("tbl%0d.q", t), 32'(mq[0]), 32'(tbl[t].data));
      @(negedge clk);
      chk($sformatf("tbl%0d.done_end", t), 32'(dne[0]), 32'(0));
    end

    @(negedge clk);
    v[0] = 1'b1; d[0] = 8'h3C; di[0] = 1'b1;
    @(negedge clk);
    d[0] = 8'hC3; di[0] = 1'b0;
    se_cnt = 0; got = 0;
    for (int i = 0; i <= 2 * N; i++) begin
      if (i == N) v[0] = 1'b0;
      if (i < 2 * N) se_cnt += int'(se[0]);
      got += int'(dne[0]);
      if (i == N - 1) chk("stream.dir_first", 32'(dr[0]), 32'(1));
      if (i == N) begin
        chk("stream.dir_second", 32'(dr[0]), 32'(0));
        chk("stream.done1", 32'(dne[0]), 32'(1));
        chk("stream.q1", 32'(mq[0]), 32'(8'h3C));
      end
      if (i == 2 * N) begin
        chk("stream.done2", 32'(dne[0]), 32'(1));
        chk("stream.q2", 32'(mq[0]), 32'(8'hC3));
        chk("stream.shift_off", 32'(se[0]), 32'(0));
      end
      @(negedge clk);
    end
    chk("stream.shift_cycles", 32'(se_cnt), 32'(2 * N));
    chk("stream.done_count", 32'(got), 32'(2));

    v[1] = 1'b1; d[1] = 8'h6B; di[1] = 1'b1;
    @(negedge clk);
    d[1] = 8'h94; di[1] = 1'b0;
    pat = '0; zero_cnt = 0;
    for (int i = 0; i <= 2 * N + 2; i++) begin
      if (i == N + 2) v[1] = 1'b0;
      pat[i] = se[1];
      if (i >= N && i < 2 * N + 2 && !se[1]) zero_cnt++;
      if (i == N) begin
        chk("gap.ready_first_gap", 32'(rdy[1]), 32'(0));
        chk("gap.done1", 32'(dne[1]), 32'(1));
        chk("gap.q1", 32'(mq[1]), 32'(8'h6B));
      end
      if (i == N + 1) chk("gap.ready_last_gap", 32'(rdy[1]), 32'(1));
      if (i == 2 * N + 2) begin
        chk("gap.done2", 32'(dne[1]), 32'(1));
        chk("gap.q2", 32'(mq[1]), 32'(8'h94));
      end
      @(negedge clk);
    end
    chk("gap.shift_pattern", pat, 32'h0003_FCFF);
    chk("gap.idle_cycles", 32'(zero_cnt), 32'(2));

    @(negedge clk);
    v[0] = 1'b1; d[0] = 8'hFF; di[0] = 1'b1;
    @(negedge clk);
    v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.shift_en", 32'(se[0]), 32'(0));
    chk("rst.dir", 32'(dr[0]), 32'(0));
    chk("rst.din", 32'(dn[0]), 32'(0));
    chk("rst.busy", 32'(bs[0]), 32'(0));
    chk("rst.done", 32'(dne[0]), 32'(0));
    repeat (2) begin
      @(negedge clk);
      chk("rst.no_done", 32'(dne[0]), 32'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready_after", 32'(rdy[0]), 32'(1));
    chk("rst.done_after", 32'(dne[0]), 32'(0));
    v[0] = 1'b1; d[0] = 8'h5A; di[0] = 1'b0;
    @(negedge clk);
    v[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 3 * N && got == 0; i++) begin
      if (dne[0]) got = 1;
      else @(negedge clk);
    end
    chk("rst.next_done_seen", 32'(got), 32'(1));
    chk("rst.next_q", 32'(mq[0]), 32'(8'h5A));

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        v[j]  = ($urandom_range(0, 3) != 0);
        d[j]  = N'($urandom);
        di[j] = 1'($urandom);
      end
    end
    @(negedge clk);
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (2 * N + 6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
